// File: rtl/mem_port_arbiter.sv
// Main-memory port arbiter shared by instruction fetch (port 0) and data cache (port 1).
// Round-robin between the two ports, one outstanding transaction at a time.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic              r_g;
  logic              r_last;
  logic [1:0]        r_ack;
  logic [DATA_W-1:0] r_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic w_grant_en;
  logic w_grant;
  logic w_done;
  logic w_unused;

  // Fetch path never writes, so we[0] is deliberately not used.
  assign w_unused = we[0];

  // Next-state and arbitration decision; DONE is a pure turnaround cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_en  = 1'b0;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (req != 2'b00) begin
          w_grant_en  = 1'b1;
          w_state_nxt = S_BUSY;
          unique case (req)
            2'b01:   w_grant = 1'b0;
            2'b10:   w_grant = 1'b1;
            default: w_grant = ~r_last;
          endcase
        end
      end
      S_BUSY: begin
        if (mem_ready) begin
          w_done      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Latch the granted request, then complete it and pulse ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_g         <= 1'b0;
      r_last      <= 1'b1;
      r_ack       <= 2'b00;
      r_rdata     <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_ack <= 2'b00;
      if (w_grant_en) begin
        r_g         <= w_grant;
        r_mem_req   <= 1'b1;
        r_mem_we    <= w_grant & we[1];
        r_mem_addr  <= w_grant ? addr1 : addr0;
        r_mem_wdata <= w_grant ? wdata1 : '0;
      end
      if (w_done) begin
        r_mem_req <= 1'b0;
        r_mem_we  <= 1'b0;
        r_rdata   <= r_mem_we ? '0 : mem_rdata;
        r_ack     <= r_g ? 2'b10 : 2'b01;
        r_last    <= r_g;
      end
    end
  end

  assign ack       = r_ack;
  assign rdata     = r_rdata;
  assign busy      = req & ~r_ack;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random traffic
// against a transaction-level reference model.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr0;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic [1:0]  ack;
  logic [31:0] rdata;
  logic [1:0]  busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata1    (wdata1),
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: one outstanding transaction, earliest next grant time.
  int          cyc = 0;
  logic        m_out;
  logic        m_p;
  logic        m_last;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [1:0]  m_ack;
  logic [31:0] m_rdata;
  logic        m_rd_chk;
  int          m_idle_from;

  int ord[$];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp,
               $time);
    end
  endtask

  task automatic model_edge();
    cyc++;
    if (reset) begin
      m_out       = 1'b0;
      m_last      = 1'b1;
      m_we        = 1'b0;
      m_ack       = 2'b00;
      m_rdata     = '0;
      m_rd_chk    = 1'b0;
      m_idle_from = cyc + 1;
    end else begin
      m_ack = 2'b00;
      if (m_out) begin
        if (mem_ready) begin
          m_out       = 1'b0;
          m_ack       = m_p ? 2'b10 : 2'b01;
          m_last      = m_p;
          m_rd_chk    = !m_we;
          m_rdata     = mem_rdata;
          m_idle_from = cyc + 2;
        end
      end else if (cyc >= m_idle_from && req != 2'b00) begin
        if (req == 2'b11) m_p = !m_last;
        else m_p = req[1];
        m_out   = 1'b1;
        m_addr  = m_p ? addr1 : addr0;
        m_we    = m_p & we[1];
        m_wdata = m_p ? wdata1 : 32'h0;
      end
    end
  endtask

  task automatic check_all();
    chk("mem_req", {63'd0, mem_req}, {63'd0, m_out});
    chk("mem_we", {63'd0, mem_we}, {63'd0, m_out & m_we});
    if (m_out) begin
      chk("mem_addr", {32'd0, mem_addr}, {32'd0, m_addr});
      chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, m_wdata});
    end
    chk("ack", {62'd0, ack}, {62'd0, m_ack});
    chk("busy", {62'd0, busy}, {62'd0, req & ~m_ack});
    if (m_ack != 2'b00 && m_rd_chk)
      chk("rdata", {32'd0, rdata}, {32'd0, m_rdata});
  endtask

  task automatic tick();
    model_edge();
    @(posedge clock);
    @(negedge clock);
    check_all();
    if (ack == 2'b01) ord.push_back(0);
    else if (ack == 2'b10) ord.push_back(1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 2'b00;
    mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    req = 2'b00;
    we = 2'b00;
    addr0 = 32'h0;
    addr1 = 32'h0;
    wdata1 = 32'h0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;

    // Reset state and a port 1 read with a two-cycle memory.
    do_reset();
    chk("rst_addr", {32'd0, mem_addr}, 64'h0);
    chk("rst_wdata", {32'd0, mem_wdata}, 64'h0);
    chk("rst_rdata", {32'd0, rdata}, 64'h0);
    req = 2'b10;
    addr1 = 32'h100;
    tick();
    chk("t1_addr", {32'd0, mem_addr}, 64'h100);
    tick();
    mem_ready = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    chk("t1_ack", {62'd0, ack}, 64'h2);
    chk("t1_rdata", {32'd0, rdata}, 64'hDEADBEEF);
    req = 2'b00;
    mem_ready = 1'b0;
    tick();
    chk("t1_ack_drop", {62'd0, ack}, 64'h0);
    tick();

    // Simultaneous requests, instant memory: port 0 first, 3 cycles apart.
    do_reset();
    ord.delete();
    req = 2'b11;
    addr0 = 32'h10;
    addr1 = 32'h8000_0020;
    mem_ready = 1'b1;
    begin
      int c0;
      int c1;
      c0 = -1;
      c1 = -1;
      for (int i = 0; i < 8; i++) begin
        tick();
        if (ack == 2'b01 && c0 < 0) c0 = i;
        if (ack == 2'b10 && c1 < 0) c1 = i;
        req = req & ~m_ack;
      end
      chk("t2_first0", {32'd0, c0}, 64'd1);
      chk("t2_gap", {32'd0, c1 - c0}, 64'd3);
    end
    chk("t2_count", {32'd0, ord.size()}, 64'd2);
    mem_ready = 1'b0;
    tick();

    // Both held: six alternating grants starting with port 0.
    ord.delete();
    req = 2'b11;
    for (int i = 0; i < 200 && ord.size() < 6; i++) begin
      mem_ready = ($urandom_range(99) < 50);
      mem_rdata = $urandom();
      tick();
    end
    chk("t3_count", {32'd0, ord.size()}, 64'd6);
    for (int i = 0; i < ord.size() && i < 6; i++)
      chk("t3_order", {32'd0, ord[i]}, {32'd0, i % 2});
    req = 2'b00;
    mem_ready = 1'b0;
    tick();
    tick();

    // Port 1 write.
    req = 2'b10;
    we = 2'b10;
    addr1 = 32'h40;
    wdata1 = 32'h12345678;
    tick();
    chk("t4_we", {63'd0, mem_we}, 64'd1);
    chk("t4_wdata", {32'd0, mem_wdata}, 64'h12345678);
    mem_ready = 1'b1;
    tick();
    chk("t4_ack", {62'd0, ack}, 64'h2);
    req = 2'b00;
    mem_ready = 1'b0;
    tick();
    tick();

    // Fetch with we[0] set is still a read.
    req = 2'b01;
    we = 2'b01;
    addr0 = 32'h80;
    tick();
    chk("t5_we", {63'd0, mem_we}, 64'd0);
    chk("t5_addr", {32'd0, mem_addr}, 64'h80);
    mem_ready = 1'b1;
    mem_rdata = 32'hCAFE0001;
    tick();
    req = 2'b00;
    we = 2'b00;
    mem_ready = 1'b0;
    tick();
    tick();

    // Reset in BUSY, then a stray mem_ready; tie goes to port 0.
    req = 2'b10;
    addr1 = 32'h8000_0300;
    tick();
    tick();
    reset = 1'b1;
    req = 2'b00;
    tick();
    reset = 1'b0;
    mem_ready = 1'b1;
    tick();
    chk("t6_ack", {62'd0, ack}, 64'h0);
    chk("t6_mreq", {63'd0, mem_req}, 64'd0);
    tick();
    req = 2'b11;
    addr0 = 32'h0000_0500;
    addr1 = 32'h8000_0600;
    tick();
    chk("t6_tie", {32'd0, mem_addr}, 64'h500);
    tick();
    req = req & ~m_ack;
    mem_ready = 1'b0;
    tick();
    req = req & ~m_ack;
    tick();

    // Random traffic with occasional resets and stray ready pulses.
    for (int i = 0; i < 3000; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (m_ack[p]) begin
          if ($urandom_range(3) != 0) req[p] = 1'b0;
        end else if (!req[p] && $urandom_range(99) < 30) begin
          req[p] = 1'b1;
        end
      end
      we = 2'($urandom_range(3));
      addr0 = $urandom() & 32'h7fff_ffff;
      addr1 = $urandom() | 32'h8000_0000;
      wdata1 = $urandom();
      mem_ready = ($urandom_range(99) < 40);
      mem_rdata = $urandom();
      reset = ($urandom_range(299) == 0);
      if (reset) req = 2'b00;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
